// File: rtl/ntt_bist_ctrl_pkg.sv
// ntt_bist_ctrl_pkg: shared defaults, state and preload-select encodings for the NTT BIST controller
package ntt_bist_ctrl_pkg;
  localparam int DEF_LOGN = 8;
  localparam int DEF_LOGQ = 64;
  localparam logic [63:0] DEF_Q = 64'h0;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN_F   = 3'd1,
    CHECK_F = 3'd2,
    GAP     = 3'd3,
    RUN_I   = 3'd4,
    CHECK_I = 3'd5,
    DONE    = 3'd6
  } state_t;
  typedef enum logic [1:0] {
    LD_DIN_F  = 2'd0,
    LD_GOLD_F = 2'd1,
    LD_DIN_I  = 2'd2,
    LD_GOLD_I = 2'd3
  } ld_sel_t;
  function automatic int aw_of(input int logn);
    return logn < 9 ? 10 : logn;
  endfunction
endpackage

// File: rtl/ntt_bist_ctrl_mem.sv
// ntt_bist_mem: N x LOGQ RAM, one write port, one registered read port (read-before-write)
module ntt_bist_mem #(
  parameter int LOGN = 8,
  parameter int LOGQ = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [LOGN-1:0] waddr,
  input  logic [LOGQ-1:0] wdata,
  input  logic [LOGN-1:0] raddr,
  output logic [LOGQ-1:0] rdata
);
  logic [LOGQ-1:0] mem [2**LOGN];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= rst ? '0 : mem[raddr];
  end
endmodule

// File: rtl/ntt_bist_ctrl.sv
// ntt_bist_ctrl: NTT wrapper self-test controller; NTT_BIST_CYCLE_COUNT_EN adds cyc_f/cyc_i run counters
module ntt_bist_ctrl
  import ntt_bist_ctrl_pkg::*;
#(
  parameter int LOGN = DEF_LOGN,
  parameter int LOGQ = DEF_LOGQ,
  parameter logic [LOGQ-1:0] Q = DEF_Q[LOGQ-1:0],
  parameter int TIMEOUT = 2**20,
  localparam int AW = aw_of(LOGN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [1:0]      mode,
  input  logic            ld_en,
  input  logic [1:0]      ld_sel,
  input  logic [LOGN-1:0] ld_addr,
  input  logic [LOGQ-1:0] ld_data,
  output logic            ntt_start,
  output logic            ntt_intt,
  output logic            ntt_btf_gs,
  input  logic [AW-1:0]   ntt_read_address,
  output logic [LOGQ-1:0] ntt_data_in,
  input  logic [AW-1:0]   ntt_write_address,
  input  logic            ntt_wea,
  input  logic [LOGQ-1:0] ntt_data_out,
  input  logic            ntt_finish,
  output logic [LOGQ-1:0] q,
  output logic            busy,
  output logic            done,
  output logic            pass_f,
  output logic            pass_i,
  output logic            timeout,
  output logic [LOGN:0]   err_cnt_f,
  output logic [LOGN:0]   err_cnt_i
`ifdef NTT_BIST_CYCLE_COUNT_EN
  ,
  output logic [63:0]     cyc_f,
  output logic [63:0]     cyc_i
`endif
);
  localparam int N = 2**LOGN;
  localparam int WW = $clog2(TIMEOUT) + 1;
  state_t state;
  logic run_i_q, fin_q, idle, rise, wd_exp, last, chk_i, miss;
  logic [WW-1:0] wd;
  logic [LOGN:0] chk, err_cur, err_nxt;
  logic [5:0] we;
  logic [LOGQ-1:0] rd [6];
  assign idle = state == IDLE || state == DONE;
  assign rise = ntt_finish && !fin_q;
  assign wd_exp = wd == WW'(TIMEOUT - 1);
  assign last = chk == (LOGN+1)'(N);
  assign chk_i = state == CHECK_I;
  assign err_cur = chk_i ? err_cnt_i : err_cnt_f;
  // chk == 0 is the read-latency slot: no data to compare yet
  assign miss = chk != '0 && (chk_i ? rd[5] != rd[3] : rd[4] != rd[1]);
  assign err_nxt = err_cur + (LOGN+1)'(miss && err_cur != (LOGN+1)'(N));
  assign ntt_data_in = state == RUN_I ? rd[2] : rd[0];
  // order: din_f, gold_f, din_i, gold_i (matches ld_sel), res_f, res_i
  assign we = {ntt_wea && state == RUN_I, ntt_wea && state == RUN_F,
               {4{ld_en && idle}} & (4'b1 << ld_sel)};
  for (genvar m = 0; m < 6; m++) begin : g_mem
    ntt_bist_mem #(.LOGN(LOGN), .LOGQ(LOGQ)) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (we[m]),
      .waddr (m < 4 ? ld_addr : ntt_write_address[LOGN-1:0]),
      .wdata (m < 4 ? ld_data : ntt_data_out),
      .raddr (m == 0 || m == 2 ? ntt_read_address[LOGN-1:0] : chk[LOGN-1:0]),
      .rdata (rd[m])
    );
  end
  if (AW > LOGN) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{ntt_read_address[AW-1:LOGN], ntt_write_address[AW-1:LOGN]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      run_i_q <= 1'b0;
      fin_q <= 1'b0;
      q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass_f <= 1'b0;
      pass_i <= 1'b0;
      timeout <= 1'b0;
      err_cnt_f <= '0;
      err_cnt_i <= '0;
      ntt_start <= 1'b0;
      ntt_intt <= 1'b0;
      ntt_btf_gs <= 1'b0;
      wd <= '0;
      chk <= '0;
`ifdef NTT_BIST_CYCLE_COUNT_EN
      cyc_f <= '0;
      cyc_i <= '0;
`endif
    end else begin
      fin_q <= ntt_finish;
      q <= Q;
      done <= 1'b0;
`ifdef NTT_BIST_CYCLE_COUNT_EN
      if (state == RUN_F && ntt_start && !ntt_finish) cyc_f <= cyc_f + 64'd1;
      if (state == RUN_I && ntt_start && !ntt_finish) cyc_i <= cyc_i + 64'd1;
`endif
      case (state)
        IDLE, DONE: if (go) begin
          run_i_q <= mode[1];
          pass_f <= 1'b0;
          pass_i <= 1'b0;
          timeout <= 1'b0;
          err_cnt_f <= '0;
          err_cnt_i <= '0;
          wd <= '0;
          ntt_start <= |mode;
          ntt_intt <= !mode[0] && mode[1];
          ntt_btf_gs <= !mode[0] && mode[1];
          busy <= |mode;
          done <= ~|mode;
          state <= mode[0] ? RUN_F : mode[1] ? RUN_I : DONE;
`ifdef NTT_BIST_CYCLE_COUNT_EN
          cyc_f <= '0;
          cyc_i <= '0;
`endif
        end
        RUN_F, RUN_I: if (rise) begin
          ntt_start <= 1'b0;
          chk <= '0;
          state <= state == RUN_F ? CHECK_F : CHECK_I;
        end else if (wd_exp) begin
          ntt_start <= 1'b0;
          timeout <= 1'b1;
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end else begin
          wd <= wd + 1'b1;
        end
        CHECK_F, CHECK_I: begin
          chk <= chk + 1'b1;
          if (chk_i) err_cnt_i <= err_nxt;
          else err_cnt_f <= err_nxt;
          if (last) begin
            if (chk_i) pass_i <= err_nxt == '0 && !timeout;
            else pass_f <= err_nxt == '0 && !timeout;
            busy <= !chk_i && run_i_q;
            done <= chk_i || !run_i_q;
            state <= !chk_i && run_i_q ? GAP : DONE;
          end
        end
        GAP: begin
          wd <= '0;
          ntt_start <= 1'b1;
          ntt_intt <= 1'b1;
          ntt_btf_gs <= 1'b1;
          state <= RUN_I;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
